car_lane_ctrl: RTL

- Upstream stage of the right-moving car sprite ROM.
- Holds the horizontal positions of NUM_CARS cars in one road lane and advances them once per video frame, wrapping at the screen edge.
- For each pixel, reports whether the pixel falls inside a car. If it does, it produces the 6-bit sprite-relative DX/DY address the ROM consumes. Output is registered, with one cycle of latency.

---
 rtl/car_lane_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/car_lane_ctrl.sv
// car_lane_ctrl
// Keeps the horizontal positions of NUM_CARS cars in one road lane. All cars
// advance together once per video frame (falling edge of vs) and wrap at the
// right edge of the screen. Every pixel is hit-tested against the cars, and a
// sprite-relative DX/DY address is registered for the car sprite ROM, one
// cycle after DrawX/DrawY.
//
// Ports
//   Clk       in   pixel clock
//   Reset_n   in   asynchronous reset, active low
//   vs        in   VGA vertical sync (active low); its falling edge is the frame tick
//   freeze    in   hold all car positions
//   DrawX/Y   in   current pixel column / row
//   level_up  in   one-cycle pulse that raises the car speed (CAR_SPEEDUP_EN only)
//   DX/DY     out  sprite column / row address for the ROM
//   car_on    out  the pixel from the previous cycle lies inside a car
//   car_idx   out  index of the car hit (valid while car_on=1)
//
// Build option: define CAR_SPEEDUP_EN to add a saturating speed register that
// level_up increments. Without it the cars move SPEED pixels per frame.
//
// State table
//   RUN    | cars advance on every frame tick
//   FROZEN | positions held; leaves when freeze drops, ignoring a tick in that cycle
//
// pos[i] is the car's right edge + 1 in screen columns; its left edge is
// pos[i]-SPRITE, so a small pos shows a car partially entering at the left.

module car_lane_ctrl #(
  parameter int NUM_CARS = 4,
  parameter int LANE_Y   = 360,
  parameter int SPRITE   = 24,
  parameter int SCREEN_W = 640,
  parameter int SPACING  = 160,
  parameter int SPEED    = 2
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       vs,
  input  logic       freeze,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic       level_up,
  output logic [5:0] DX,
  output logic [5:0] DY,
  output logic       car_on,
  output logic [2:0] car_idx
);

  localparam logic [10:0] WRAP = 11'(SCREEN_W + SPRITE);
  localparam logic [10:0] SPR  = 11'(SPRITE);

  typedef enum logic {RUN, FROZEN} state_t;

  state_t      state_q, state_d;
  logic        vs_q;
  logic        frame_tick;
  logic        move;
  logic [4:0]  spd;
  logic [10:0] pos_q   [NUM_CARS];
  logic [10:0] pos_nxt [NUM_CARS];
  logic [10:0] rx      [NUM_CARS];
  logic [10:0] dy;

  logic [5:0]  dx_q, dx_d;
  logic [5:0]  dy_q, dy_d;
  logic        on_q, on_d;
  logic [2:0]  idx_q, idx_d;

  assign frame_tick = vs_q & ~vs;

`ifdef CAR_SPEEDUP_EN
  logic [4:0] spd_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      spd_q <= 5'(SPEED);
    end else if (level_up && (spd_q < 5'(SPRITE - 1))) begin
      spd_q <= spd_q + 5'd1;
    end
  end

  assign spd = spd_q;
`else
  logic unused_level_up;
  assign unused_level_up = level_up;
  assign spd = 5'(SPEED);
`endif

  // FSM next state; a tick only moves cars while running and not being frozen
  always_comb begin
    state_d = state_q;
    move    = 1'b0;
    case (state_q)
      RUN: begin
        if (freeze) begin
          state_d = FROZEN;
        end else begin
          move = frame_tick;
        end
      end
      FROZEN: begin
        if (!freeze) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // Per-car advance with wrap, and hit offset relative to the car's left edge.
  // rx underflows to a large value for columns left of the car, so a single
  // unsigned compare against SPRITE covers both bounds.
  for (genvar g = 0; g < NUM_CARS; g++) begin : g_car
    logic [10:0] n;
    assign n          = pos_q[g] + {6'b0, spd};
    assign pos_nxt[g] = (n >= WRAP) ? (n - WRAP) : n;
    assign rx[g]      = {1'b0, DrawX} + SPR - pos_q[g];
  end

  assign dy = {1'b0, DrawY} - 11'(LANE_Y);

  // Descending scan so the lowest-index hit is the one left standing
  always_comb begin
    on_d  = 1'b0;
    idx_d = 3'd0;
    dx_d  = 6'd0;
    dy_d  = 6'd0;
    if (dy < SPR) begin
      for (int i = NUM_CARS - 1; i >= 0; i--) begin
        if (rx[i] < SPR) begin
          on_d  = 1'b1;
          idx_d = 3'(i);
          dx_d  = rx[i][5:0];
          dy_d  = dy[5:0];
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= RUN;
      vs_q    <= 1'b1;
      for (int i = 0; i < NUM_CARS; i++) begin
        pos_q[i] <= 11'(i * SPACING + SPRITE);
      end
      dx_q  <= 6'd0;
      dy_q  <= 6'd0;
      on_q  <= 1'b0;
      idx_q <= 3'd0;
    end else begin
      state_q <= state_d;
      vs_q    <= vs;
      if (move) begin
        for (int i = 0; i < NUM_CARS; i++) begin
          pos_q[i] <= pos_nxt[i];
        end
      end
      dx_q  <= dx_d;
      dy_q  <= dy_d;
      on_q  <= on_d;
      idx_q <= idx_d;
    end
  end

  assign DX      = dx_q;
  assign DY      = dy_q;
  assign car_on  = on_q;
  assign car_idx = idx_q;

endmodule
